// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) split over LAT register stages
// with a valid/ready handshake at both ends, flush, and a passthrough tag.
module shifter_pipe #(
  parameter  int N     = 32,
  parameter  int LAT   = 2,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int BPS = (SHW + LAT - 1) / LAT;
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  // Right-shift log-stages lo..hi-1; SLL arrives here already bit-reversed.
  function automatic logic [N-1:0] log_shift(input logic [N-1:0] d,
                                             input logic [SHW-1:0] sh,
                                             input logic [1:0] op,
                                             input logic sg,
                                             input int lo,
                                             input int hi);
    logic [N-1:0] r;
    logic [N-1:0] fill;
    r = d;
    for (int k = 0; k < SHW; k++) begin
      if (k >= lo && k < hi && sh[k]) begin
        if (op == OP_ROR) begin
          r = (r >> (1 << k)) | (r << (N - (1 << k)));
        end else begin
          fill = (op == OP_SRA && sg) ? ~({N{1'b1}} >> (1 << k)) : '0;
          r = (r >> (1 << k)) | fill;
        end
      end
    end
    return r;
  endfunction

  logic [LAT-1:0]   v_q;
  logic [LAT-1:0]   adv;
  logic [N-1:0]     d_q   [LAT];
  logic [SHW-1:0]   sh_q  [LAT];
  logic [1:0]       op_q  [LAT];
  logic             sg_q  [LAT];
  logic [TAG_W-1:0] tg_q  [LAT];

  logic             up_v  [LAT];
  logic [N-1:0]     up_d  [LAT];
  logic [SHW-1:0]   up_sh [LAT];
  logic [1:0]       up_op [LAT];
  logic             up_sg [LAT];
  logic [TAG_W-1:0] up_tg [LAT];
  logic [N-1:0]     d_nx  [LAT];

  always_comb begin
    logic a;
    a = out_ready | ~v_q[LAT-1];
    adv = '0;
    adv[LAT-1] = a;
    for (int j = LAT - 2; j >= 0; j--) begin
      a = a | ~v_q[j];
      adv[j] = a;
    end
  end

  always_comb begin
    up_v[0]  = in_valid;
    up_d[0]  = (in_op == OP_SLL) ? bit_rev(in_a) : in_a;
    up_sh[0] = in_shamt;
    up_op[0] = in_op;
    up_sg[0] = in_a[N-1];
    up_tg[0] = in_tag;
    for (int j = 1; j < LAT; j++) begin
      up_v[j]  = v_q[j-1];
      up_d[j]  = d_q[j-1];
      up_sh[j] = sh_q[j-1];
      up_op[j] = op_q[j-1];
      up_sg[j] = sg_q[j-1];
      up_tg[j] = tg_q[j-1];
    end
    for (int j = 0; j < LAT; j++) begin
      d_nx[j] = log_shift(up_d[j], up_sh[j], up_op[j], up_sg[j], j * BPS,
                          ((j + 1) * BPS < SHW) ? (j + 1) * BPS : SHW);
    end
  end

  // Flush wins over every transfer; data registers only load on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int j = 0; j < LAT; j++) begin
        d_q[j]  <= '0;
        sh_q[j] <= '0;
        op_q[j] <= '0;
        sg_q[j] <= 1'b0;
        tg_q[j] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int j = 0; j < LAT; j++) begin
        if (adv[j]) begin
          v_q[j]  <= up_v[j];
          d_q[j]  <= d_nx[j];
          sh_q[j] <= up_sh[j];
          op_q[j] <= up_op[j];
          sg_q[j] <= up_sg[j];
          tg_q[j] <= up_tg[j];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LAT-1];
  assign out_y     = (op_q[LAT-1] == OP_SLL) ? bit_rev(d_q[LAT-1]) : d_q[LAT-1];
  assign out_tag   = tg_q[LAT-1];

endmodule
